// File: rtl/mb_r4_seq_td_if.sv
// Operand/result handshake bundle for the iterative radix-4 Booth multiplier.
// The producer/consumer side uses the master modport and the multiplier uses slave.
interface mb_r4_seq_td_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   signed_mode;
    logic [WIDTH-1:0]       mx1;
    logic [WIDTH-1:0]       my1;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product1;
    logic [WIDTH-1:0]       mx_reg;
    logic [WIDTH-1:0]       my_reg;
    logic                   busy;

    modport slave (
        input  in_valid, signed_mode, mx1, my1, out_ready,
        output in_ready, out_valid, product1, mx_reg, my_reg, busy
    );

    modport master (
        output in_valid, signed_mode, mx1, my1, out_ready,
        input  in_ready, out_valid, product1, mx_reg, my_reg, busy
    );
endinterface

// File: rtl/mb_r4_seq_td.sv
// Iterative radix-4 Booth multiplier, one Booth digit retired per clock.
// Operands are captured on the accept edge and extended by two bits (sign or zero),
// so signed and unsigned products share one datapath. The multiplicand is kept
// pre-shifted and the multiplier is shifted right two bits per step, which avoids
// a variable barrel shift in the accumulate path.
module mb_r4_seq_td #(
    parameter int WIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    mb_r4_seq_td_if.slave     bus
);
    localparam int N_DIG = WIDTH / 2 + 1;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CNT_W = $clog2(N_DIG);
    localparam int EXT_W = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   mcand;
    logic [ACC_W-1:0]   pp;
    logic [EXT_W:0]     mplr;
    logic [EXT_W-1:0]   mx_ext;
    logic [EXT_W-1:0]   my_ext;
    logic               accept;
    logic               last;

    assign accept = (state == IDLE) && bus.in_valid && !clr;
    assign last   = (state == RUN) && (cnt == CNT_W'(N_DIG - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.out_valid = (state == DONE);

    // Extend the raw operands by two bits according to the requested mode.
    always_comb begin
        mx_ext = {2'b00, bus.mx1};
        my_ext = {2'b00, bus.my1};
        if (bus.signed_mode) begin
            mx_ext = {{2{bus.mx1[WIDTH-1]}}, bus.mx1};
            my_ext = {{2{bus.my1[WIDTH-1]}}, bus.my1};
        end
    end

    // Recode the current multiplier triplet into a partial product of -2..+2 times the multiplicand.
    always_comb begin
        pp = '0;
        case (mplr[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        acc_sum = acc + pp;
    end

    // State register; reset drops straight back to IDLE and discards any operation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush overrides every other transition.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid) state_next = RUN;
                RUN:     if (last) state_next = DONE;
                DONE:    if (bus.out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand capture, per-digit accumulation and result load.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.product1 <= '0;
            bus.mx_reg   <= '0;
            bus.my_reg   <= '0;
            acc          <= '0;
            cnt          <= '0;
            mcand        <= '0;
            mplr         <= '0;
        end else if (clr) begin
            bus.product1 <= '0;
            bus.mx_reg   <= '0;
            bus.my_reg   <= '0;
            acc          <= '0;
            cnt          <= '0;
            mcand        <= '0;
            mplr         <= '0;
        end else if (accept) begin
            bus.mx_reg <= bus.mx1;
            bus.my_reg <= bus.my1;
            mcand      <= {{(ACC_W - EXT_W){mx_ext[EXT_W-1]}}, mx_ext};
            mplr       <= {my_ext, 1'b0};
            acc        <= '0;
            cnt        <= '0;
        end else if (state == RUN) begin
            acc   <= acc_sum;
            mcand <= mcand << 2;
            mplr  <= mplr >> 2;
            cnt   <= cnt + 1'b1;
            if (last) begin
                bus.product1 <= acc_sum[2*WIDTH-1:0];
            end
        end
    end
endmodule
